neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/nn_pkg.sv | 28 ++
 rtl/neuron_coef_rf.sv | 47 ++++
 rtl/neuron_mac.sv | 180 ++++++++++++++++++
 tb/tb_neuron_mac.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg -- shared definitions for the neuron_mac datapath.
//   state_t     : neuron FSM states (IDLE, ACCUM, BIAS, OUT)
//   DATA_W_DEF  : default signed width of activations, weights, bias, output
//   FRAC_W_DEF  : default fractional bits of the fixed-point format
//   sat_hi/lo() : largest / smallest value representable in a signed w-bit word
// -----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 13;

    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/neuron_coef_rf.sv
// -----------------------------------------------------------------------------
// neuron_coef_rf -- coefficient register file for one neuron.
// Holds NUM_IN weights (index 0..NUM_IN-1) and the bias (index NUM_IN).
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset, clears every coefficient
//   we     : write strobe (already qualified by the caller's FSM state)
//   addr   : write index; indices above NUM_IN are dropped
//   wdata  : coefficient value
//   raddr  : weight read index (combinational read)
//   rdata  : weight at raddr
//   bias   : bias coefficient
// -----------------------------------------------------------------------------
module neuron_coef_rf
    import nn_pkg::*;
#(
    parameter int NUM_IN = 5,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [$clog2(NUM_IN+1)-1:0]    addr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [$clog2(NUM_IN+1)-1:0]    raddr,
    output logic [DATA_W-1:0]              rdata,
    output logic [DATA_W-1:0]              bias
);

    localparam int ADDR_W = $clog2(NUM_IN + 1);

    logic [DATA_W-1:0] mem [NUM_IN+1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= NUM_IN; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (addr <= ADDR_W'(NUM_IN))) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
    assign bias  = mem[NUM_IN];

endmodule

// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac -- single fixed-point neuron: sum(act[k]*W[k]) + B, rescaled,
// saturated and optionally rectified.
// Optional feature macro: NEURON_MAC_RELU_EN (negative results forced to 0).
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   w_we      : coefficient write strobe (honoured only while idle)
//   w_addr    : coefficient index, 0..NUM_IN-1 weights, NUM_IN bias
//   w_data    : signed coefficient value
//   in_valid  : activation beat valid
//   in_ready  : activation beat accepted when in_valid && in_ready
//   in_data   : signed activation, beat k pairs with weight k
//   out_valid : result valid, held until out_ready
//   out_ready : downstream accepts the result
//   out_data  : signed neuron result
//   out_sat   : result was clipped by saturation
// -----------------------------------------------------------------------------
module neuron_mac
    import nn_pkg::*;
#(
    parameter int NUM_IN = 5,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           w_we,
    input  logic [$clog2(NUM_IN+1)-1:0]    w_addr,
    input  logic [DATA_W-1:0]              w_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_sat
);

    localparam int ADDR_W = $clog2(NUM_IN + 1);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + $clog2(NUM_IN);
    // One guard bit over the wider of acc and the shifted bias keeps the
    // bias addition exact.
    localparam int SUM_W  = ((ACC_W > DATA_W + FRAC_W) ? ACC_W : DATA_W + FRAC_W) + 1;
    localparam logic [ADDR_W-1:0]       LAST_K  = ADDR_W'(NUM_IN - 1);
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(sat_hi(DATA_W));
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(sat_lo(DATA_W));

    state_t state, state_nxt;

    logic                     accept;
    logic                     coef_we;
    logic [ADDR_W-1:0]        k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] act;
    logic signed [DATA_W-1:0] w_rd;
    logic signed [DATA_W-1:0] b_rd;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  r;
    logic signed [DATA_W-1:0] res_d;
    logic                     res_sat;
    logic signed [DATA_W-1:0] out_q;
    logic                     sat_q;

    function automatic logic signed [DATA_W-1:0] sat_val(input logic signed [SUM_W-1:0] v);
        if (v > SUM_MAX) begin
            return DATA_W'(SUM_MAX);
        end else if (v < SUM_MIN) begin
            return DATA_W'(SUM_MIN);
        end
        return DATA_W'(v);
    endfunction

    function automatic logic is_clipped(input logic signed [SUM_W-1:0] v);
        return (v > SUM_MAX) || (v < SUM_MIN);
    endfunction

    neuron_coef_rf #(
        .NUM_IN (NUM_IN),
        .DATA_W (DATA_W)
    ) u_coef (
        .clk   (clk),
        .reset (reset),
        .we    (coef_we),
        .addr  (w_addr),
        .wdata (w_data),
        .raddr (k),
        .rdata (w_rd),
        .bias  (b_rd)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = (NUM_IN == 1) ? ST_BIAS : ST_ACCUM;
            ST_ACCUM: if (accept && (k == LAST_K)) state_nxt = ST_BIAS;
            ST_BIAS:  state_nxt = ST_OUT;
            ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
        out_valid = (state == ST_OUT);
        // Coefficients are frozen while a frame is in flight.
        coef_we   = w_we && (state == ST_IDLE);
    end

    assign accept = in_valid && in_ready;

    // ---------------- Datapath: multiply ----------------
    assign act      = in_data;
    assign prod     = PROD_W'(act) * PROD_W'(w_rd);
    assign prod_ext = ACC_W'(prod);

    // ---------------- Datapath: bias, rescale, saturate ----------------
    assign sum = SUM_W'(acc) + (SUM_W'(b_rd) <<< FRAC_W);
    assign r   = sum >>> FRAC_W;

    always_comb begin
        res_d   = sat_val(r);
        res_sat = is_clipped(r);
`ifdef NEURON_MAC_RELU_EN
        if (res_d < 0) begin
            res_d   = '0;
            res_sat = 1'b0;
        end
`endif
    end

    // ---------------- Datapath: accumulate and register result ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            k     <= '0;
            out_q <= '0;
            sat_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc <= prod_ext;
                        k   <= ADDR_W'(1);
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc <= acc + prod_ext;
                        k   <= k + ADDR_W'(1);
                    end
                end
                ST_BIAS: begin
                    out_q <= res_d;
                    sat_q <= res_sat;
                    k     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_q;
    assign out_sat  = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac -- self-checking bench for neuron_mac (NUM_IN=5, DATA_W=16,
// FRAC_W=13). Expected results come from fixed vectors or from a plain
// arithmetic model of the neuron equation over a shadow coefficient table.
// -----------------------------------------------------------------------------
module tb_neuron_mac;

    localparam int NUM_IN = 5;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 13;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w_we = 1'b0;
    logic [2:0]  w_addr = '0;
    logic [15:0] w_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_sat;

    int errors = 0;
    int checks = 0;
    int wm   [NUM_IN+1];
    int acts [NUM_IN];

    neuron_mac #(
        .NUM_IN (NUM_IN),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Neuron equation: floor((sum a*w + B*2^F) / 2^F), clipped to 16 bits.
    task automatic model(output logic [15:0] d, output logic s);
        longint acc_sum;
        longint r;
        acc_sum = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            acc_sum += longint'(acts[i]) * longint'(wm[i]);
        end
        acc_sum += longint'(wm[NUM_IN]) * (longint'(1) << FRAC_W);
        r = acc_sum >>> FRAC_W;
        s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
`ifdef NEURON_MAC_RELU_EN
        if (r < 0) begin
            r = 0;
            s = 1'b0;
        end
`endif
        d = 16'(r);
    endtask

    task automatic write_coef(input int addr, input int data, input bit land);
        w_we   = 1'b1;
        w_addr = 3'(addr);
        w_data = 16'(data);
        tick();
        w_we = 1'b0;
        if (land) wm[addr] = data;
    endtask

    task automatic load(input int w0, input int w1, input int w2, input int w3,
                        input int w4, input int b);
        write_coef(0, w0, 1'b1);
        write_coef(1, w1, 1'b1);
        write_coef(2, w2, 1'b1);
        write_coef(3, w3, 1'b1);
        write_coef(4, w4, 1'b1);
        write_coef(5, b, 1'b1);
    endtask

    task automatic set_acts(input int a0, input int a1, input int a2, input int a3, input int a4);
        acts[0] = a0; acts[1] = a1; acts[2] = a2; acts[3] = a3; acts[4] = a4;
    endtask

    task automatic send_beats(input int first, input int last, input int stall_max);
        int n;
        for (int i = first; i <= last; i++) begin
            n = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
            in_valid = 1'b0;
            repeat (n) tick();
            in_valid = 1'b1;
            in_data  = 16'(acts[i]);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL beat_ready beat=%0d in_ready=%b expected 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Called right after the final beat's edge.
    task automatic finish_frame(input string name, input logic [15:0] exp_d,
                                input logic exp_s, input int hold);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_bias_cycle out_valid=%b in_ready=%b expected 0/0", name, out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency out_valid=%b expected 1", name, out_valid);
        end
        checks++;
        if (out_data !== exp_d) begin
            errors++;
            $display("FAIL %s_data out_data=%0d expected %0d", name, $signed(out_data), $signed(exp_d));
        end
        checks++;
        if (out_sat !== exp_s) begin
            errors++;
            $display("FAIL %s_sat out_sat=%b expected %b", name, out_sat, exp_s);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_sat !== exp_s) begin
                errors++;
                $display("FAIL %s_hold cycle=%0d valid=%b data=%0d sat=%b expected 1/%0d/%b",
                         name, h, out_valid, $signed(out_data), out_sat, $signed(exp_d), exp_s);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic run_model_frame(input string name, input int stall_max, input int hold);
        logic [15:0] d;
        logic        s;
        model(d, s);
        send_beats(0, NUM_IN - 1, stall_max);
        finish_frame(name, d, s, hold);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i <= NUM_IN; i++) wm[i] = 0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs valid=%b data=%0d sat=%b ready=%b expected 0/0/0/1",
                     out_valid, out_data, out_sat, in_ready);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load(8192, -8192, 0, 0, 0, -139);
        set_acts(4096, 2048, 0, 0, 0);
        send_beats(0, NUM_IN - 1, 0);
        finish_frame("basic", 16'd1909, 1'b0, 0);
    endtask

    task automatic test_saturation();
        load(8192, 8192, 8192, 8192, 8192, 0);
        set_acts(8192, 8192, 8192, 8192, 8192);
        send_beats(0, NUM_IN - 1, 1);
        finish_frame("saturate", 16'd32767, 1'b1, 0);
    endtask

    task automatic test_reset_midframe();
        load(8192, -8192, 0, 0, 0, -139);
        set_acts(4096, 2048, 0, 0, 0);
        send_beats(0, 2, 0);
        checks++;
        if (out_data !== 16'd32767 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL prev_result_held data=%0d sat=%b expected 32767/1", out_data, out_sat);
        end
        #2;
        reset = 1'b0;
        for (int i = 0; i <= NUM_IN; i++) wm[i] = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midframe_reset valid=%b data=%0d sat=%b ready=%b expected 0/0/0/1",
                     out_valid, out_data, out_sat, in_ready);
        end
        tick();
        reset = 1'b1;
        tick();
        set_acts(1234, -5000, 777, 32000, -32768);
        run_model_frame("cleared_coefs", 1, 0);
        load(8192, -8192, 0, 0, 0, -139);
        set_acts(4096, 2048, 0, 0, 0);
        send_beats(0, NUM_IN - 1, 0);
        finish_frame("after_reset", 16'd1909, 1'b0, 0);
    endtask

    task automatic test_relu();
        load(-8192, 0, 0, 0, 0, 0);
        set_acts(1000, 321, -4000, 99, 12345);
        send_beats(0, NUM_IN - 1, 0);
`ifdef NEURON_MAC_RELU_EN
        finish_frame("relu", 16'd0, 1'b0, 0);
`else
        finish_frame("linear_neg", 16'hFC18, 1'b0, 0);
`endif
    endtask

    task automatic test_backpressure();
        load(8192, -8192, 0, 0, 0, -139);
        set_acts(4096, 2048, 0, 0, 0);
        send_beats(0, NUM_IN - 1, 0);
        tick();
        for (int h = 0; h < 10; h++) begin
            // Activations and a bias write offered while the result waits must be ignored.
            in_valid = 1'b1;
            in_data  = 16'h1111;
            w_we     = (h == 0);
            w_addr   = 3'd5;
            w_data   = 16'd77;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd1909 || out_sat !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle=%0d valid=%b data=%0d sat=%b ready=%b expected 1/1909/0/0",
                         h, out_valid, $signed(out_data), out_sat, in_ready);
            end
            tick();
        end
        in_valid  = 1'b0;
        w_we      = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        send_beats(0, NUM_IN - 1, 0);
        finish_frame("after_backpressure", 16'd1909, 1'b0, 0);
    endtask

    task automatic test_accum_write();
        load(8192, -8192, 0, 0, 0, -139);
        set_acts(4096, 2048, 0, 0, 0);
        send_beats(0, 1, 0);
        write_coef(0, 0, 1'b0);
        write_coef(5, 500, 1'b0);
        send_beats(2, NUM_IN - 1, 1);
        finish_frame("accum_write", 16'd1909, 1'b0, 0);
        run_model_frame("accum_write_kept", 0, 0);
    endtask

    task automatic test_same_edge();
        load(8192, -8192, 0, 0, 0, -139);
        set_acts(4096, 2048, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = 16'(acts[0]);
        w_we     = 1'b1;
        w_addr   = 3'd0;
        w_data   = 16'd0;
        tick();
        w_we = 1'b0;
        send_beats(1, NUM_IN - 1, 0);
        finish_frame("same_edge_old", 16'd1909, 1'b0, 0);
        wm[0] = 0;
        run_model_frame("same_edge_new", 0, 0);
    endtask

    task automatic test_bad_addr();
        load(8192, -8192, 0, 0, 0, -139);
        write_coef(6, 1234, 1'b0);
        write_coef(7, -1, 1'b0);
        set_acts(4096, 2048, 0, 0, 0);
        run_model_frame("bad_addr", 0, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            if ((f == 0) || ($urandom_range(1, 0) == 1)) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    write_coef(i, int'($urandom_range(16384, 0)) - 8192, 1'b1);
                end
                write_coef(NUM_IN, int'($urandom_range(4000, 0)) - 2000, 1'b1);
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if ($urandom_range(1, 0) == 1)
                    acts[i] = int'($urandom_range(65535, 0)) - 32768;
                else
                    acts[i] = int'($urandom_range(8192, 0)) - 4096;
            end
            run_model_frame("random", 2, int'($urandom_range(3, 0)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_reset_midframe();
        test_relu();
        test_backpressure();
        test_accum_write();
        test_same_edge();
        test_bad_addr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
